// File: rtl/dpram_burst_pkg.sv
// Shared types for the dpram burst initiator: FSM state encoding and burst direction.
package dpram_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_t;

endpackage

// File: rtl/dpram_burst_skid.sv
// Two-entry registered FIFO for the read path; the head entry drives the read stream directly.
module dpram_burst_skid #(
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  logic [data_width-1:0] entry0, entry1;
  logic [1:0]            count;
  logic                  push, pop;

  // A full buffer still takes a word when the head leaves in the same cycle.
  assign in_ready  = (count != 2'd2) | out_ready;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = entry0;
  assign out_valid = (count != 2'd0);
  assign occupancy = count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= in_data;
          else               entry1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= in_data;
          end else begin
            entry0 <= entry1;
            entry1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dpram_burst_ctrl.sv
// Burst initiator for one dpram port: streams write data in, read data out through a skid buffer.
// Define DPRAM_BURST_NOWRAP_EN to reject bursts that would cross the top of the address space.
//
// state    | meaning
// ST_IDLE  | waiting for a command, RAM deselected
// ST_WRITE | accepting write beats, one RAM write per handshake
// ST_READ  | issuing reads while the skid has room
// ST_DRAIN | all reads issued, emptying the skid
module dpram_burst_ctrl
  import dpram_burst_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [addr_width-1:0] cmd_len,
  input  logic [data_width-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [data_width-1:0] rdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [addr_width-1:0] ram_address,
  output logic [data_width-1:0] ram_data,
  output logic                  ram_enable,
  output logic                  ram_wren,
  output logic                  ram_cs,
  input  logic [data_width-1:0] ram_q
);

  localparam int cnt_width = addr_width + 1;
  localparam logic [cnt_width-1:0]  cnt_one  = {{addr_width{1'b0}}, 1'b1};
  localparam logic [addr_width-1:0] addr_one = {{(addr_width-1){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [addr_width-1:0] addr_q;
  logic [cnt_width-1:0]  cnt_q, out_cnt_q;
  logic                  in_flight_q, done_q, err_q, ready_en_q;
  logic                  cmd_fire, reject, wr_fire, rd_issue, rd_pop;
  logic                  skid_in_ready;
  logic [1:0]            skid_occ;
  logic [2:0]            eff_occ;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign wr_fire  = wdata_valid & wdata_ready;
  assign rd_pop   = rdata_valid & rdata_ready;

  // Occupancy as it will be after this cycle's pop, so a draining head does not stall issue.
  assign eff_occ  = {1'b0, skid_occ} + {2'b00, in_flight_q} - {2'b00, rd_pop};
  assign rd_issue = (state == ST_READ) && (eff_occ < 3'd2) && skid_in_ready;

`ifdef DPRAM_BURST_NOWRAP_EN
  logic [cnt_width-1:0] span;
  assign span   = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign reject = cmd_fire & span[addr_width];
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (cmd_fire && !reject)
          state_nxt = (dir_t'(cmd_write) == DIR_WRITE) ? ST_WRITE : ST_READ;
      ST_WRITE:
        if (wr_fire && cnt_q == cnt_one) state_nxt = ST_IDLE;
      ST_READ:
        if (rd_issue && cnt_q == cnt_one) state_nxt = ST_DRAIN;
      ST_DRAIN:
        if (rd_pop && out_cnt_q == cnt_one) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    busy        = 1'b0;
    ram_enable  = 1'b0;
    ram_wren    = 1'b0;
    ram_cs      = 1'b0;
    ram_data    = '0;
    case (state)
      ST_IDLE: cmd_ready = ready_en_q;
      ST_WRITE: begin
        busy        = 1'b1;
        wdata_ready = 1'b1;
        ram_enable  = wdata_valid;
        ram_wren    = wdata_valid;
        ram_cs      = wdata_valid;
        ram_data    = wdata_valid ? wdata : '0;
      end
      ST_READ: begin
        busy       = 1'b1;
        ram_cs     = 1'b1;
        ram_enable = rd_issue;
      end
      ST_DRAIN: begin
        busy   = 1'b1;
        // ram_q reads as all-ones once CS drops, so keep it up for the last capture.
        ram_cs = in_flight_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_q      <= '0;
      cnt_q       <= '0;
      out_cnt_q   <= '0;
      in_flight_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= reject;
      in_flight_q <= rd_issue;
      case (state)
        ST_IDLE:
          if (cmd_fire && !reject) begin
            addr_q    <= cmd_addr;
            cnt_q     <= {1'b0, cmd_len} + cnt_one;
            out_cnt_q <= {1'b0, cmd_len} + cnt_one;
          end
        ST_WRITE:
          if (wr_fire) begin
            addr_q <= addr_q + addr_one;
            cnt_q  <= cnt_q - cnt_one;
            done_q <= (cnt_q == cnt_one);
          end
        ST_READ, ST_DRAIN: begin
          if (rd_issue) begin
            addr_q <= addr_q + addr_one;
            cnt_q  <= cnt_q - cnt_one;
          end
          if (rd_pop) begin
            out_cnt_q <= out_cnt_q - cnt_one;
            done_q    <= (out_cnt_q == cnt_one);
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_address = addr_q;
  assign done        = done_q;
  assign err         = err_q;

  dpram_burst_skid #(.data_width(data_width)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (ram_q),
    .in_valid  (in_flight_q),
    .in_ready  (skid_in_ready),
    .out_data  (rdata),
    .out_valid (rdata_valid),
    .out_ready (rdata_ready),
    .occupancy (skid_occ)
  );

endmodule

// File: tb/tb_dpram_burst_ctrl.sv
// Randomized bench for dpram_burst_ctrl with a behavioural RAM, a burst-level reference model and directed pins.
module tb_dpram_burst_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_len = '0, wdata = '0;
  logic       wdata_valid = 1'b0, rdata_ready = 1'b0;
  logic       cmd_ready, wdata_ready, rdata_valid, busy, done, err;
  logic       ram_enable, ram_wren, ram_cs;
  logic [7:0] rdata, ram_address, ram_data, ram_q;

  always #5 clock = ~clock;

  dpram_burst_ctrl #(.addr_width(8), .data_width(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .busy(busy), .done(done), .err(err),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_enable(ram_enable), .ram_wren(ram_wren), .ram_cs(ram_cs),
    .ram_q(ram_q)
  );

  // Behavioural dpram port: one-cycle read latency, output forced high while deselected.
  logic [7:0] ram [256];
  logic [7:0] q_reg;
  always @(posedge clock) begin
    if (ram_enable && ram_cs) begin
      if (ram_wren) ram[ram_address] <= ram_data;
      else          q_reg <= ram[ram_address];
    end
  end
  assign ram_q = ram_cs ? q_reg : 8'hFF;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Read-stream back-pressure: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1.
  int       ready_mode = 0;
  int       pidx = 0;
  bit [3:0] pat = 4'b1001;
  always begin
    @(posedge clock);
    #1;
    pidx++;
    case (ready_mode)
      0:       rdata_ready = 1'b1;
      1:       rdata_ready = 1'($urandom_range(0, 1));
      default: rdata_ready = pat[pidx % 4];
    endcase
  end

  // Reference model: burst bookkeeping and intended memory image.
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q[$];
  logic [7:0] rd_log[$];
  int  cycle = 0;
  bit  burst_on = 0, burst_wr = 0, first_seen = 0, done_due = 0, prev_stall = 0;
  int  cur_addr = 0, beats_total = 0, beats_done = 0, issued = 0, cmd_cyc = 0;
  int  last_done_delta = 0;
  logic [7:0] prev_rdata = '0;

  always @(negedge clock) begin : monitor
    bit wr_hs, rd_pop, rd_iss;
    cycle++;
    if (!reset_n) begin
      burst_on   = 0;
      done_due   = 0;
      prev_stall = 0;
      exp_q.delete();
    end else begin
      check("done pulse", done, done_due);
      if (done_due) begin
        check("cmd_ready with done", cmd_ready, 1);
        last_done_delta = cycle - cmd_cyc;
      end
      done_due = 0;
      check("err quiet", err, 0);
      if (prev_stall) check("rdata hold", {rdata_valid, rdata}, {1'b1, prev_rdata});
      prev_stall = rdata_valid && !rdata_ready;
      prev_rdata = rdata;
      wr_hs = burst_on && burst_wr && wdata_valid && wdata_ready;
      check("write strobe", ram_enable && ram_wren, wr_hs);
      if (!burst_on) begin
        check("idle outputs", {busy, ram_enable, rdata_valid}, 0);
        if (cmd_valid && cmd_ready) begin
          burst_on    = 1;
          burst_wr    = cmd_write;
          cur_addr    = int'(cmd_addr);
          beats_total = int'(cmd_len) + 1;
          beats_done  = 0;
          issued      = 0;
          cmd_cyc     = cycle;
          first_seen  = 0;
          if (!cmd_write)
            for (int i = 0; i < beats_total; i++) exp_q.push_back(ref_mem[8'(cur_addr + i)]);
        end
      end else if (burst_wr) begin
        if (wr_hs) begin
          check("write beat", {ram_cs, ram_address, ram_data}, {1'b1, 8'(cur_addr + beats_done), wdata});
          ref_mem[8'(cur_addr + beats_done)] = wdata;
          beats_done++;
          if (beats_done == beats_total) begin
            burst_on = 0;
            done_due = 1;
          end
        end
      end else begin
        rd_iss = ram_enable && ram_cs && !ram_wren;
        if (rd_iss) issued++;
        if (rdata_valid && !first_seen) begin
          first_seen = 1;
          check("first rdata latency", cycle - cmd_cyc, 3);
        end
        if (ready_mode == 0 && cycle >= cmd_cyc + 3) check("read streaming", rdata_valid, 1);
        rd_pop = rdata_valid && rdata_ready;
        if (rd_pop) begin
          if (exp_q.size() == 0) check("read overrun", 1, 0);
          else                   check("read data", rdata, exp_q.pop_front());
          rd_log.push_back(rdata);
          beats_done++;
          if (beats_done == beats_total) begin
            burst_on = 0;
            done_due = 1;
          end
        end
        check("outstanding le 2", (issued - beats_done) <= 2, 1);
        check("no over-issue", issued <= beats_total, 1);
      end
    end
  end

  logic [7:0] wlist [4];

  task automatic send_cmd(input bit w, input int a, input int l);
    int t = 0;
    cmd_write = w;
    cmd_addr  = 8'(a);
    cmd_len   = 8'(l);
    cmd_valid = 1'b1;
    @(negedge clock);
    while (!cmd_ready && t < 100) begin
      t++;
      @(negedge clock);
    end
    if (!cmd_ready) check("cmd_ready timeout", 0, 1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!done && t < 3000);
    if (!done) check("done timeout", 0, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input int a, input int l, input bit use_list, input int gap);
    int t;
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= l; i++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        wdata_valid = 1'b0;
        @(posedge clock);
        #1;
      end
      wdata       = use_list ? wlist[i % 4] : 8'($urandom);
      wdata_valid = 1'b1;
      t = 0;
      @(negedge clock);
      while (!wdata_ready && t < 50) begin
        t++;
        @(negedge clock);
      end
      if (!wdata_ready) check("wdata_ready timeout", 0, 1);
      @(posedge clock);
      #1;
    end
    wdata_valid = 1'b0;
    wait_done();
  endtask

  task automatic do_read(input int a, input int l, input int mode);
    ready_mode = mode;
    send_cmd(1'b0, a, l);
    wait_done();
  endtask

  task automatic reset_and_check();
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("outputs in reset",
          {cmd_ready, wdata_ready, rdata, rdata_valid, busy, done, err,
           ram_address, ram_data, ram_enable, ram_wren, ram_cs}, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("cmd_ready before release edge", cmd_ready, 0);
    @(negedge clock);
    check("cmd_ready after release", cmd_ready, 1);
    @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    int base, t, diffs;
    repeat (2) @(posedge clock);
    reset_and_check();

    // Whole-RAM write with an all-ones length fills every word.
    do_write(0, 255, 1'b0, 0);

    wlist[0] = 8'hA0; wlist[1] = 8'hA1; wlist[2] = 8'hA2; wlist[3] = 8'hA3;
    do_write(8'h10, 3, 1'b1, 0);
    check("write done delay", last_done_delta, 5);
    for (int i = 0; i < 4; i++) check("ram 0x10 burst", ram[8'(16 + i)], 8'(8'hA0 + i));

    base = rd_log.size();
    do_read(8'h10, 3, 0);
    check("read done delay", last_done_delta, 7);
    check("read beat count", rd_log.size() - base, 4);
    for (int i = 0; i < 4; i++) check("read 0x10 data", rd_log[base + i], 8'(8'hA0 + i));

    base = rd_log.size();
    pidx = 0;
    do_read(8'h10, 3, 2);
    check("stalled read count", rd_log.size() - base, 4);
    for (int i = 0; i < 4; i++) check("stalled read data", rd_log[base + i], 8'(8'hA0 + i));

    wlist[0] = 8'h11; wlist[1] = 8'h22; wlist[2] = 8'h33; wlist[3] = 8'h44;
    do_write(8'hFE, 3, 1'b1, 0);
    check("wrap 0xFE", ram[8'hFE], 8'h11);
    check("wrap 0xFF", ram[8'hFF], 8'h22);
    check("wrap 0x00", ram[8'h00], 8'h33);
    check("wrap 0x01", ram[8'h01], 8'h44);

    base = rd_log.size();
    do_read(8'h00, 0, 0);
    check("single beat count", rd_log.size() - base, 1);
    if (rd_log.size() > base) check("single beat data", rd_log[base], 8'h33);

    // Reset in the middle of an 8-beat read.
    ready_mode = 0;
    base = rd_log.size();
    send_cmd(1'b0, 8'h10, 7);
    t = 0;
    while (rd_log.size() < base + 2 && t < 50) begin
      t++;
      @(negedge clock);
    end
    check("beats before reset", rd_log.size() - base >= 2, 1);
    reset_and_check();
    base = rd_log.size();
    do_read(8'h11, 0, 0);
    check("post-reset read count", rd_log.size() - base, 1);
    if (rd_log.size() > base) check("post-reset read data", rd_log[base], 8'hA1);

    do_read(8'h37, 255, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(0, 255), $urandom_range(0, 20), 1'b0, $urandom_range(0, 40));
      else
        do_read($urandom_range(0, 255), $urandom_range(0, 20), $urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end

    diffs = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) diffs++;
    check("ram image", diffs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dpram_burst_ctrl.md
# dpram_burst_ctrl

Burst initiator for one port of the `dpram` true dual-port RAM. It accepts a burst command (start address, beat count, direction) and streams write data into the RAM port or read data out of it, using valid/ready handshakes on both streams. It absorbs the RAM's one-cycle read latency and chip-select gating, and supports back-pressure on the read stream. It sits between a client such as a DMA or a CPU bus bridge and a `dpram` port.

## Interface
- `addr_width`, 8, RAM address width; must match the attached `dpram`.
- `data_width`, 8, RAM word width.
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`; reset 0, then 1 from the first cycle after reset release.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  addr_width  first word address.
- `cmd_len`  in  addr_width  beat count minus one (0 = 1 beat).
- `wdata`/`wdata_valid`  in  data_width/1  write stream.
- `wdata_ready`  out  1  reset 0.
- `rdata`  out  data_width  read stream; reset 0.
- `rdata_valid`  out  1  reset 0.
- `rdata_ready`  in  1  read-stream back-pressure.
- `busy`  out  1  high outside IDLE; reset 0.
- `done`  out  1  one-cycle pulse at burst end; reset 0.
- `err`  out  1  one-cycle pulse on a rejected command; reset 0.
- `ram_address`/`ram_data`  out  addr_width/data_width  to `address_x`/`data_x`; reset 0.
- `ram_enable`, `ram_wren`, `ram_cs`  out  1 each  to `enable_x`/`wren_x`/`cs_x`; reset 0.
- `ram_q`  in  data_width  from `q_x`; valid the cycle after a read enable, only while `ram_cs`=1.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: `cmd_ready`=1. On handshake, latch address and beat counter (addr_width+1 bits, loaded with `cmd_len`+1), then go to WRITE or READ.
- WRITE: `wdata_ready`=1.
  - Each `wdata` handshake drives `ram_enable`=`ram_wren`=`ram_cs`=1 combinationally, with the current address and `wdata`.
  - The word is stored at that edge. The address increments and the counter decrements.
  - The last beat goes to IDLE with `done`=1 in the following cycle.
- READ: issue a read (`ram_enable`=`ram_cs`=1, `ram_wren`=0) only when skid occupancy plus the in-flight beat is less than 2.
  - The captured `ram_q` enters the skid buffer.
  - After the last issue, go to DRAIN.
- DRAIN: hold `ram_cs`=1 through the capture cycle of the last issued beat. `ram_q` is forced to all-ones when CS is low, so releasing CS early corrupts the last word.
  - Exit to IDLE once the skid is empty and every beat has been handshaken. `done` pulses in the first IDLE cycle.
- `ram_enable`=0 whenever no beat is issued. `ram_cs`=0 in IDLE.
- Address arithmetic is modulo 2^addr_width: 0xFF+1 wraps to 0x00 at width 8.
- `cmd_len` of all-ones yields 2^addr_width beats, the whole RAM.
- Reset mid-burst: return to IDLE immediately, flush the skid, and drive all outputs to their reset values. Writes already performed stay in RAM. No `done` is generated.

## Timing
- Write: handshake in cycle n means the data is in RAM at the end of cycle n (zero added latency). Throughput is 1 beat per cycle.
- Read: command handshake in cycle n, first issue in n+1, `ram_q` valid in n+2, `rdata_valid` from n+3.
- With `rdata_ready` held high, throughput is 1 beat per cycle.
- `rdata`/`rdata_valid` are registered. `rdata` holds while `rdata_valid`=1 and `rdata_ready`=0.
- `done` comes 1 cycle after the final handshake. `cmd_ready` rises the same cycle as `done`.

## Configuration
- `DPRAM_BURST_NOWRAP_EN` defined: a command whose `cmd_addr`+`cmd_len` exceeds 2^addr_width−1 is consumed in IDLE with no RAM access. It pulses `err` the next cycle, and the controller remains in IDLE.
- Undefined: addresses wrap as described above, and `err` is tied to 0.

## Structure
- Package `dpram_burst_pkg`: state enum, burst-direction constants.
- Sub-module `dpram_burst_skid`: 2-entry registered FIFO (parameter `data_width`) with valid/ready on both sides and an occupancy output. It holds the read path.

## Test plan
- Write burst `cmd_addr`=0x10, `cmd_len`=3, data 0xA0..0xA3 with `wdata_valid` constant: RAM 0x10..0x13 = 0xA0..0xA3, `done` pulses 1 cycle after the 4th beat.
- Read the same range with `rdata_ready`=1: `rdata` = 0xA0..0xA3 on consecutive cycles, the first at command cycle + 3.
- Read with `rdata_ready` toggling 1,0,0,1: no loss or duplication, `rdata` held while stalled, never more than 2 beats outstanding.
- Write at 0xFE with `cmd_len`=3: without the macro, data lands at 0xFE, 0xFF, 0x00, 0x01. With the macro, `err` pulses and RAM is unchanged.
- Assert `reset_n`=0 after 2 of 8 read beats: next cycle all outputs are at reset values, then `cmd_ready`=1, and a new 1-beat read returns correct data.
- `cmd_len`=0 read at 0x00: exactly 1 `rdata` beat, and `ram_cs` stays high through the capture cycle.
